// File: rtl/tcs_rgb_classify.sv
// ============================================================================
// tcs_rgb_classify: normalises TCS34725 raw R/G/B against clear to 8 bits with
// one shared serial divider, then classifies the dominant colour.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tcs_rgb_classify #(
  parameter logic [15:0] DARK_THRESH  = 16'd64,
  parameter logic [7:0]  WHITE_THRESH = 8'd200,
  parameter logic [7:0]  MARGIN       = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] data_clear,
  input  logic [15:0] data_red,
  input  logic [15:0] data_green,
  input  logic [15:0] data_blue,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  red8,
  output logic [7:0]  green8,
  output logic [7:0]  blue8,
  output logic [2:0]  color_id,
  output logic [7:0]  drop_cnt
);

  localparam logic [2:0] c_ID_DARK    = 3'd0;
  localparam logic [2:0] c_ID_RED     = 3'd1;
  localparam logic [2:0] c_ID_GREEN   = 3'd2;
  localparam logic [2:0] c_ID_BLUE    = 3'd3;
  localparam logic [2:0] c_ID_WHITE   = 3'd4;
  localparam logic [2:0] c_ID_UNKNOWN = 3'd5;
  localparam logic [4:0] c_DIV_LAST   = 5'd23;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_R, S_DIV_R, S_LOAD_G, S_DIV_G,
    S_LOAD_B, S_DIV_B, S_CLASSIFY, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] clr_q, clr_d, red_raw_q, red_raw_d, grn_raw_q, grn_raw_d, blu_raw_q, blu_raw_d;
  logic [23:0] num_q, num_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  r8_q, r8_d, g8_q, g8_d, b8_q, b8_d;
  logic [2:0]  cls_q, cls_d;
  logic [7:0]  red8_q, red8_d, green8_q, green8_d, blue8_q, blue8_d;
  logic [2:0]  color_q, color_d;
  logic        out_valid_q, out_valid_d, busy_q, busy_d;
  logic [7:0]  drop_q, drop_d;

  logic [15:0] w_x;
  logic [23:0] w_x255;
  logic [16:0] w_rem_shift, w_rem_sub;
  logic        w_ge;
  logic [23:0] w_quo;
  logic [7:0]  w_div_res;
  logic [7:0]  w_max, w_sec;
  logic [2:0]  w_max_id;

  // Channel currently owning the divider.
  always_comb begin
    case (state_q)
      S_LOAD_G, S_DIV_G: w_x = grn_raw_q;
      S_LOAD_B, S_DIV_B: w_x = blu_raw_q;
      default:           w_x = red_raw_q;
    endcase
  end

  assign w_x255      = ({8'd0, w_x} << 8) - {8'd0, w_x};
  assign w_rem_shift = {rem_q, num_q[23]};
  assign w_rem_sub   = w_rem_shift - {1'b0, clr_q};
  assign w_ge        = (w_rem_shift >= {1'b0, clr_q});
  assign w_quo       = {num_q[22:0], w_ge};
  // Zero clear and X >= C are overridden; the raw quotient is only trusted when it fits 8 bits.
  assign w_div_res   = (clr_q == 16'd0) ? 8'd0 :
                       (w_x >= clr_q)   ? 8'hFF : w_quo[7:0];

  always_comb begin
    if (r8_q >= g8_q && r8_q >= b8_q) begin
      w_max = r8_q;  w_max_id = c_ID_RED;
      w_sec = (g8_q >= b8_q) ? g8_q : b8_q;
    end else if (g8_q >= b8_q) begin
      w_max = g8_q;  w_max_id = c_ID_GREEN;
      w_sec = (r8_q >= b8_q) ? r8_q : b8_q;
    end else begin
      w_max = b8_q;  w_max_id = c_ID_BLUE;
      w_sec = (r8_q >= g8_q) ? r8_q : g8_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    red_raw_d   = red_raw_q;
    grn_raw_d   = grn_raw_q;
    blu_raw_d   = blu_raw_q;
    num_d       = num_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    r8_d        = r8_q;
    g8_d        = g8_q;
    b8_d        = b8_q;
    cls_d       = cls_q;
    red8_d      = red8_q;
    green8_d    = green8_q;
    blue8_d     = blue8_q;
    color_d     = color_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    drop_d      = drop_q;

    if (sample_valid && busy_q && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          clr_d     = data_clear;
          red_raw_d = data_red;
          grn_raw_d = data_green;
          blu_raw_d = data_blue;
          busy_d    = 1'b1;
          state_d   = S_LOAD_R;
        end
      end
      S_LOAD_R, S_LOAD_G, S_LOAD_B: begin
        num_d = w_x255;
        rem_d = 16'd0;
        cnt_d = 5'd0;
        case (state_q)
          S_LOAD_R: state_d = S_DIV_R;
          S_LOAD_G: state_d = S_DIV_G;
          default:  state_d = S_DIV_B;
        endcase
      end
      S_DIV_R, S_DIV_G, S_DIV_B: begin
        rem_d = w_ge ? w_rem_sub[15:0] : w_rem_shift[15:0];
        num_d = w_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == c_DIV_LAST) begin
          case (state_q)
            S_DIV_R: begin r8_d = w_div_res; state_d = S_LOAD_G;   end
            S_DIV_G: begin g8_d = w_div_res; state_d = S_LOAD_B;   end
            default: begin b8_d = w_div_res; state_d = S_CLASSIFY; end
          endcase
        end
      end
      S_CLASSIFY: begin
        if (clr_q < DARK_THRESH)
          cls_d = c_ID_DARK;
        else if (r8_q >= WHITE_THRESH && g8_q >= WHITE_THRESH && b8_q >= WHITE_THRESH)
          cls_d = c_ID_WHITE;
        else if ((w_max - w_sec) >= MARGIN)
          cls_d = w_max_id;
        else
          cls_d = c_ID_UNKNOWN;
        state_d = S_OUT;
      end
      S_OUT: begin
        red8_d      = r8_q;
        green8_d    = g8_q;
        blue8_d     = b8_q;
        color_d     = cls_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      clr_q       <= 16'd0;
      red_raw_q   <= 16'd0;
      grn_raw_q   <= 16'd0;
      blu_raw_q   <= 16'd0;
      num_q       <= 24'd0;
      rem_q       <= 16'd0;
      cnt_q       <= 5'd0;
      r8_q        <= 8'd0;
      g8_q        <= 8'd0;
      b8_q        <= 8'd0;
      cls_q       <= 3'd0;
      red8_q      <= 8'd0;
      green8_q    <= 8'd0;
      blue8_q     <= 8'd0;
      color_q     <= 3'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      red_raw_q   <= red_raw_d;
      grn_raw_q   <= grn_raw_d;
      blu_raw_q   <= blu_raw_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      r8_q        <= r8_d;
      g8_q        <= g8_d;
      b8_q        <= b8_d;
      cls_q       <= cls_d;
      red8_q      <= red8_d;
      green8_q    <= green8_d;
      blue8_q     <= blue8_d;
      color_q     <= color_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign red8      = red8_q;
  assign green8    = green8_q;
  assign blue8     = blue8_q;
  assign color_id  = color_q;
  assign drop_cnt  = drop_q;

endmodule

`default_nettype wire

// File: doc/tcs_rgb_classify.md
Name: tcs_rgb_classify

Overview:
- Downstream consumer of the TCS34725 read controller.
- Latches the four 16-bit raw channels (clear, red, green, blue) on each read-done pulse.
- Normalises red, green and blue against clear to 8-bit values (X*255/C) using one shared serial shift-subtract divider.
- Classifies the dominant colour and presents the result with a one-cycle valid strobe for display/LCD logic.

Parameters:
- DARK_THRESH, 16'd64: clear count below this classifies as DARK.
- WHITE_THRESH, 8'd200: all three normalised channels >= this classifies as WHITE.
- MARGIN, 8'd16: the largest normalised channel must exceed the second largest by >= MARGIN to be declared dominant.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- sample_valid, in, 1: one-cycle pulse; raw channels are valid in the same cycle (driven by the controller's done).
- data_clear, in, 16: raw clear count.
- data_red, in, 16: raw red count.
- data_green, in, 16: raw green count.
- data_blue, in, 16: raw blue count.
- busy, out, 1: high from the capture edge until out_valid is issued.
- out_valid, out, 1: one-cycle result strobe.
- red8, out, 8: normalised red.
- green8, out, 8: normalised green.
- blue8, out, 8: normalised blue.
- color_id, out, 3: 0 DARK, 1 RED, 2 GREEN, 3 BLUE, 4 WHITE, 5 UNKNOWN.
- drop_cnt, out, 8: saturating count of samples dropped while busy.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, divider cleared. Reset mid-operation aborts the computation; no out_valid is produced.
- FSM states: IDLE -> LOAD_R -> DIV_R -> LOAD_G -> DIV_G -> LOAD_B -> DIV_B -> CLASSIFY -> OUT -> IDLE.
- IDLE: sample_valid high at edge 0 captures all four channels into internal registers, sets busy=1 and moves to LOAD_R.
- LOAD_x (1 cycle): numerator = X*255 (24 bits), denominator = C, remainder = 0.
- DIV_x (exactly 24 cycles): restoring shift-subtract, one quotient bit per cycle.
- Divide result, applied after DIV_x:
  - C = 0: result 0.
  - X >= C: result 255.
  - Otherwise: result = floor(X*255/C), which always fits in 8 bits.
  - Saturated and C=0 channels still spend the full 25 cycles, so latency is fixed.
- CLASSIFY (1 cycle), first match wins:
  - C < DARK_THRESH: DARK.
  - All three normalised channels >= WHITE_THRESH: WHITE.
  - max - second >= MARGIN: the max channel (RED, GREEN or BLUE).
  - Otherwise: UNKNOWN. Equal maxima therefore always give UNKNOWN.
- OUT: red8/green8/blue8/color_id update together; out_valid=1 for exactly one cycle; busy drops to 0 on the same edge.
- Latency: out_valid is high in the cycle following edge 77 counted from the capture edge (3*25 + CLASSIFY + OUT).
- Output hold: result outputs hold their values until the next OUT. They never change while out_valid is low.
- sample_valid while busy=1 (including the OUT cycle): the sample is ignored and drop_cnt increments, saturating at 255.
- sample_valid in IDLE in the cycle right after OUT: accepted normally.
- Raw inputs are sampled only at the capture edge; input changes afterwards have no effect.

Test Plan:
- Nominal red: C=1000, R=500, G=250, B=100 pulse -> after 77 edges out_valid one cycle; red8=127, green8=63, blue8=25, color_id=1; busy high throughout.
- Saturation and zero clear:
  - C=1000, R=2000, G=0, B=0 -> red8=255, green8=0, blue8=0, color_id=1.
  - C=0, all channels 500 -> red8/green8/blue8=0, color_id=0, same 77-edge latency.
- White and unknown:
  - C=300, R=G=B=280 -> each channel 238, color_id=4.
  - C=1000, R=500, G=480, B=0 -> 127/122/0, color_id=5.
- Dark with valid ratios: C=50, R=25, G=10, B=5 -> red8=127, green8=51, blue8=25, color_id=0.
- Drop while busy: second sample_valid at edge 10 with different data -> drop_cnt=1, result reflects the first sample only.
  - 300 pulses while busy (one per busy window) -> drop_cnt saturates at 255.
- Async reset: pull rst low at edge 40 mid-DIV_G -> all outputs 0 immediately, no out_valid.
  - Release rst and send a new sample -> correct result 77 edges later.
